// File: rtl/event_decoder_pkg.sv
// Shared types and header codes for the AER receive-side event decoder.
package event_decoder_pkg;

  localparam logic [3:0] HDR_TIME_HIGH = 4'b1000;
  localparam logic [3:0] HDR_CD_ON     = 4'b0001;
  localparam logic [3:0] HDR_CD_OFF    = 4'b0000;

  localparam int EVT_X_W  = 4;
  localparam int EVT_Y_W  = 4;
  localparam int EVT_TS_W = 34;

  typedef enum logic {
    NO_BASE   = 1'b0,
    HAVE_BASE = 1'b1
  } dec_state_t;

  typedef struct packed {
    logic [EVT_X_W-1:0]  x;
    logic [EVT_Y_W-1:0]  y;
    logic                pol;
    logic [EVT_TS_W-1:0] ts;
  } decoded_evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO with a registered head: head always mirrors the oldest entry.
module evt_fifo #(
  parameter int W     = 43,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count;
  logic          push_ok, pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + AW'(1);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      count <= count + CW'(push_ok) - CW'(pop_ok);
      // New word becomes head when the FIFO is (or is about to be) empty.
      if (push_ok && (empty || (count == CW'(1) && pop_ok)))
        head <= din;
      else if (pop_ok && count > CW'(1))
        head <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/event_decoder.sv
// Rebuilds full AER events from time-high / CD_ON / CD_OFF words and buffers them
// behind a valid/ready interface, flagging bad headers, orphans and overflow.
module event_decoder
  import event_decoder_pkg::*;
#(
  parameter int ROW_ADD    = 4,
  parameter int COL_ADD    = 4,
  parameter int SIZE       = 34,
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               valid_data_i,
  input  logic [WIDTH-1:0]   data_i,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [ROW_ADD-1:0] evt_x_o,
  output logic [COL_ADD-1:0] evt_y_o,
  output logic               evt_pol_o,
  output logic [SIZE-1:0]    evt_ts_o,
  output logic               hdr_err_o,
  output logic               ts_err_o,
  output logic               overflow_o,
  output logic [7:0]         drop_cnt_o
);

  localparam int TL_LSB = ROW_ADD + COL_ADD;
  localparam int EVT_W  = $bits(decoded_evt_t);

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [3:0]       hdr;
  logic [5:0]       time_low;
  logic [SIZE-1:0]  ts_new;
  logic             is_th, is_evt, is_bad;
  logic             drop_p0, ovf_p1, evt_pop;
  logic             fifo_full, fifo_empty;
  dec_state_t       state_q;
  logic [WIDTH-5:0] time_high_q;
  logic [SIZE-1:0]  last_ts_q;
  decoded_evt_t     evt_p0, head;
  logic             vld_p0;

  assign hdr      = data_i[WIDTH-1 -: 4];
  assign time_low = data_i[TL_LSB+5 : TL_LSB];
  assign ts_new   = {time_high_q, time_low};
  assign is_th    = (hdr == HDR_TIME_HIGH);
  assign is_evt   = (hdr == HDR_CD_ON) || (hdr == HDR_CD_OFF);
  assign is_bad   = !is_th && !is_evt;

  assign drop_p0  = valid_data_i && (is_bad || (is_evt && state_q == NO_BASE));
  assign evt_pop  = evt_valid_o && evt_ready_i;
  assign ovf_p1   = vld_p0 && fifo_full && !evt_pop;

  // p0: decode the incoming word against the current time base
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= NO_BASE;
      time_high_q <= '0;
      last_ts_q   <= '0;
      hdr_err_o   <= 1'b0;
      ts_err_o    <= 1'b0;
      vld_p0      <= 1'b0;
      evt_p0      <= '0;
    end else begin
      hdr_err_o <= 1'b0;
      ts_err_o  <= 1'b0;
      vld_p0    <= 1'b0;
      if (valid_data_i) begin
        if (is_th) begin
          time_high_q <= data_i[WIDTH-5:0];
          state_q     <= HAVE_BASE;
        end else if (is_evt) begin
          if (state_q == HAVE_BASE) begin
            vld_p0    <= 1'b1;
            evt_p0    <= '{x: data_i[TL_LSB-1:COL_ADD], y: data_i[COL_ADD-1:0],
                           pol: hdr[0], ts: ts_new};
            last_ts_q <= ts_new;
            ts_err_o  <= (ts_new < last_ts_q);
          end
        end else begin
          hdr_err_o <= 1'b1;
        end
      end
    end
  end

  // p1: push into the buffer; drops from p0 and p1 may land in the same cycle
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      drop_cnt_o <= sat_add(drop_cnt_o, {1'b0, drop_p0} + {1'b0, ovf_p1});
      if (ovf_p1) overflow_o <= 1'b1;
    end
  end

  evt_fifo #(
    .W    (EVT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .push    (vld_p0),
    .din     (evt_p0),
    .pop     (evt_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (head)
  );

  assign evt_valid_o = !fifo_empty;
  assign evt_x_o     = head.x;
  assign evt_y_o     = head.y;
  assign evt_pol_o   = head.pol;
  assign evt_ts_o    = head.ts;

endmodule

// File: tb/tb_event_decoder.sv
// Scoreboard bench for event_decoder: directed words, expected events queued, monitor checks.
module tb_event_decoder;

  typedef struct packed {
    logic [3:0]  x;
    logic [3:0]  y;
    logic        pol;
    logic [33:0] ts;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        valid_data_i;
  logic [31:0] data_i;
  logic        evt_valid_o;
  logic        evt_ready_i;
  logic [3:0]  evt_x_o;
  logic [3:0]  evt_y_o;
  logic        evt_pol_o;
  logic [33:0] evt_ts_o;
  logic        hdr_err_o;
  logic        ts_err_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  event_decoder dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .valid_data_i(valid_data_i),
    .data_i      (data_i),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_x_o     (evt_x_o),
    .evt_y_o     (evt_y_o),
    .evt_pol_o   (evt_pol_o),
    .evt_ts_o    (evt_ts_o),
    .hdr_err_o   (hdr_err_o),
    .ts_err_o    (ts_err_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] thw(input logic [27:0] th);
    return {4'b1000, th};
  endfunction

  function automatic logic [31:0] evw(input logic pol, input logic [5:0] tl,
                                      input logic [3:0] x, input logic [3:0] y);
    return {3'b000, pol, 14'h0, tl, x, y};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input logic [3:0] x, input logic [3:0] y, input logic pol,
                            input logic [33:0] ts);
    q.push_back('{x: x, y: y, pol: pol, ts: ts});
  endtask

  task automatic send(input logic [31:0] w);
    data_i       = w;
    valid_data_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_data_i = 1'b0;
    data_i       = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk_i);
    #1;
    chk(name, q.size(), 0);
  endtask

  // Monitor: every accepted event is compared against the oldest expectation.
  always @(negedge clk_i) begin
    if (reset_ni && evt_valid_o && evt_ready_i) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_evt actual=x%0h y%0h pol%0b ts%0h required=none",
                 evt_x_o, evt_y_o, evt_pol_o, evt_ts_o);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({evt_x_o, evt_y_o, evt_pol_o, evt_ts_o} !== e) begin
          failures++;
          $display("FAIL evt_out actual=x%0h y%0h pol%0b ts%0h required=x%0h y%0h pol%0b ts%0h",
                   evt_x_o, evt_y_o, evt_pol_o, evt_ts_o, e.x, e.y, e.pol, e.ts);
        end
      end
    end
  end

  initial begin
    reset_ni     = 1'b0;
    valid_data_i = 1'b0;
    data_i       = '0;
    evt_ready_i  = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", evt_valid_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_errs", {hdr_err_o, ts_err_o}, 0);
    chk("rst_fields", {evt_x_o, evt_y_o, evt_pol_o, evt_ts_o}, 0);
    reset_ni = 1'b1;
    idle(1);

    // Orphan events before any time base
    send(evw(1, 6'd3, 4'd2, 4'd7));
    chk("orphan_drop1", drop_cnt_o, 1);
    send(evw(0, 6'd1, 4'd1, 4'd1));
    chk("orphan_drop2", drop_cnt_o, 2);
    idle(3);
    chk("orphan_novalid", evt_valid_o, 0);

    // Basic decode and latency
    send(thw(28'h5));
    send(evw(1, 6'd3, 4'd2, 4'd7));
    expect_evt(4'd2, 4'd7, 1'b1, 34'h143);
    chk("lat_early", evt_valid_o, 0);
    idle(1);
    chk("lat_valid", evt_valid_o, 1);
    chk("lat_ts", evt_ts_o, 34'h143);
    wait_drain("drain_basic");

    // Bad header in HAVE_BASE
    send({4'b0110, 28'h123});
    chk("hdr_err_pulse", hdr_err_o, 1);
    chk("hdr_drop", drop_cnt_o, 3);
    idle(1);
    chk("hdr_err_clear", hdr_err_o, 0);
    send(evw(1, 6'd4, 4'd1, 4'd1));
    expect_evt(4'd1, 4'd1, 1'b1, 34'h144);
    chk("hdr_next_noerr", hdr_err_o, 0);
    wait_drain("drain_hdr");

    // Overflow with sink stalled
    evt_ready_i = 1'b0;
    for (int k = 1; k <= 5; k++)
      send(evw(k[0], 6'(9 + k), 4'(k), 4'(k + 1)));
    expect_evt(4'd1, 4'd2, 1'b1, 34'h14A);
    expect_evt(4'd2, 4'd3, 1'b0, 34'h14B);
    expect_evt(4'd3, 4'd4, 1'b1, 34'h14C);
    expect_evt(4'd4, 4'd5, 1'b0, 34'h14D);
    idle(1);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_drop", drop_cnt_o, 4);
    idle(3);
    chk("hold_valid", evt_valid_o, 1);
    chk("hold_head", {evt_x_o, evt_ts_o}, {4'd1, 34'h14A});
    evt_ready_i = 1'b1;
    wait_drain("drain_ovf");
    chk("ovf_sticky", overflow_o, 1);

    // Asynchronous reset with events buffered
    evt_ready_i = 1'b0;
    send(evw(1, 6'd20, 4'd2, 4'd2));
    send(evw(0, 6'd21, 4'd3, 4'd3));
    idle(2);
    chk("pre_rst_valid", evt_valid_o, 1);
    reset_ni = 1'b0;
    #1;
    chk("midrst_valid", evt_valid_o, 0);
    chk("midrst_drop", drop_cnt_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_fields", {evt_x_o, evt_ts_o}, 0);
    #2;
    reset_ni = 1'b1;
    idle(1);
    evt_ready_i = 1'b1;
    send(evw(1, 6'd7, 4'd5, 4'd5));
    chk("post_rst_orphan", drop_cnt_o, 1);
    idle(3);
    chk("post_rst_novalid", evt_valid_o, 0);

    // Non-monotonic timestamp
    send(thw(28'h2));
    send(evw(0, 6'd10, 4'd3, 4'd4));
    expect_evt(4'd3, 4'd4, 1'b0, 34'h8A);
    chk("ts_ok", ts_err_o, 0);
    send(thw(28'h1));
    send(evw(1, 6'd5, 4'd5, 4'd6));
    expect_evt(4'd5, 4'd6, 1'b1, 34'h45);
    chk("ts_err_pulse", ts_err_o, 1);
    idle(1);
    chk("ts_err_clear", ts_err_o, 0);
    wait_drain("drain_ts");
    chk("final_drop", drop_cnt_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
